// File: rtl/serial_w_tx.sv
// Serial w/z drive side: shifts a parallel word out on w, one bit per Clock,
// and counts the registered z=1 responses that come back one cycle behind each bit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | Ready=1, waiting for Load; ZCount holds the last result
// S_SHIFT   | WIDTH cycles, bit k of the word on w with WValid=1
// S_COLLECT | one cycle, w idle, z for the last bit is sampled
// S_DONE    | one cycle, Done=1, Ready=1; Load here starts the next word
module serial_w_tx #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic [WIDTH-1:0]             Data,
    input  logic                         Load,
    output logic                         Ready,
    output logic                         w,
    output logic                         WValid,
    input  logic                         z_in,
    output logic                         Done,
    output logic [$clog2(WIDTH+1)-1:0]   ZCount
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_COLLECT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BW-1:0]    bitcnt, bitcnt_nxt;
    logic             ready_nxt, w_nxt, wvalid_nxt, done_nxt;
    logic [CW-1:0]    zcount_nxt;
    logic             zval;
    logic             accept;

    // Next-state, next-output and shift/count logic; every output is registered below.
    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        bitcnt_nxt = bitcnt;
        w_nxt      = IDLE_LEVEL;
        wvalid_nxt = 1'b0;
        done_nxt   = 1'b0;
        ready_nxt  = 1'b0;
        accept     = 1'b0;
        zcount_nxt = ZCount;
        // ZVal marks the cycle in which z_in reflects the previous bit on w.
        if (zval && z_in) begin
            zcount_nxt = ZCount + 1'b1;
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (Load) begin
                    accept = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (bitcnt == LAST_BIT) begin
                    state_nxt = S_COLLECT;
                end else begin
                    bitcnt_nxt = bitcnt + 1'b1;
                    wvalid_nxt = 1'b1;
                    w_nxt      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                    shreg_nxt  = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                           : {1'b0, shreg[WIDTH-1:1]};
                end
            end
            S_COLLECT: begin
                state_nxt = S_DONE;
                done_nxt  = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // The first bit goes onto w on the accept edge itself, so the shift
        // register keeps only the bits still to be sent.
        if (accept) begin
            state_nxt  = S_SHIFT;
            bitcnt_nxt = '0;
            wvalid_nxt = 1'b1;
            w_nxt      = MSB_FIRST ? Data[WIDTH-1] : Data[0];
            shreg_nxt  = MSB_FIRST ? {Data[WIDTH-2:0], 1'b0}
                                   : {1'b0, Data[WIDTH-1:1]};
            zcount_nxt = '0;
        end

        ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_DONE);
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state  <= S_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            Ready  <= 1'b1;
            w      <= IDLE_LEVEL;
            WValid <= 1'b0;
            Done   <= 1'b0;
            ZCount <= '0;
            zval   <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            bitcnt <= bitcnt_nxt;
            Ready  <= ready_nxt;
            w      <= w_nxt;
            WValid <= wvalid_nxt;
            Done   <= done_nxt;
            ZCount <= zcount_nxt;
            zval   <= WValid;
        end
    end

endmodule

// File: tb/tb_serial_w_tx.sv
// Directed bench for serial_w_tx: an MSB-first and an LSB-first instance, a
// Moore "11" detector model closing the w/z loop, and hand-computed expectations.
module tb_serial_w_tx;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [7:0] dat;
    logic       ld;
    logic       lsb_sel;
    int         zmode;

    logic       Ready_m, w_m, WValid_m, Done_m;
    logic [3:0] ZCount_m;
    logic       Ready_l, w_l, WValid_l, Done_l;
    logic [3:0] ZCount_l;
    logic       Load_m, Load_l, z_src, z_det;
    logic [1:0] det_s;

    logic       cur_ready, cur_w, cur_wvalid, cur_done;
    logic [3:0] cur_zc;

    int ntotal = 0;
    int npass  = 0;
    int nfail  = 0;

    always #5 Clock = ~Clock;

    serial_w_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .Clock(Clock), .Resetn(Resetn), .Data(dat), .Load(Load_m), .Ready(Ready_m),
        .w(w_m), .WValid(WValid_m), .z_in(z_src), .Done(Done_m), .ZCount(ZCount_m));

    serial_w_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .Clock(Clock), .Resetn(Resetn), .Data(dat), .Load(Load_l), .Ready(Ready_l),
        .w(w_l), .WValid(WValid_l), .z_in(z_src), .Done(Done_l), .ZCount(ZCount_l));

    assign Load_m     = ld & ~lsb_sel;
    assign Load_l     = ld & lsb_sel;
    assign cur_ready  = lsb_sel ? Ready_l  : Ready_m;
    assign cur_w      = lsb_sel ? w_l      : w_m;
    assign cur_wvalid = lsb_sel ? WValid_l : WValid_m;
    assign cur_done   = lsb_sel ? Done_l   : Done_m;
    assign cur_zc     = lsb_sel ? ZCount_l : ZCount_m;
    assign z_det      = (det_s == 2'd2);
    assign z_src      = (zmode == 0) ? 1'b0 : (zmode == 1) ? 1'b1 : z_det;

    // Moore detector model: z=1 while two or more consecutive ones have been seen.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) det_s <= 2'd0;
        else if (!cur_w) det_s <= 2'd0;
        else if (det_s != 2'd2) det_s <= det_s + 2'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One word: seq lists the bits in send order, seq[7] first.
    task automatic xfer(input logic [7:0] d, input logic [7:0] seq, input int zexp,
                        input bit poke, input bit chained, input bit hold,
                        input logic [7:0] nxt);
        if (!chained) begin
            chk("ready idle", cur_ready, 1);
            dat = d;
            ld  = 1'b1;
        end
        @(negedge Clock);
        if (!hold) ld = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("w bit%0d", k), cur_w, seq[7-k]);
            chk($sformatf("wvalid bit%0d", k), cur_wvalid, 1);
            if (k == 0) begin
                chk("ready shift", cur_ready, 0);
                chk("zcount cleared", cur_zc, 0);
            end
            if (poke && k == 3) begin
                ld  = 1'b1;
                dat = 8'h3C;
            end
            if (poke && k == 4) begin
                chk("ready while poked", cur_ready, 0);
                ld = 1'b0;
            end
            @(negedge Clock);
        end
        chk("collect wvalid", cur_wvalid, 0);
        chk("collect w", cur_w, 0);
        chk("collect done", cur_done, 0);
        chk("collect ready", cur_ready, 0);
        if (poke) begin
            ld  = 1'b1;
            dat = 8'hC3 ^ 8'hFF;
        end
        if (hold) dat = nxt;
        @(negedge Clock);
        chk("done pulse", cur_done, 1);
        chk("done ready", cur_ready, 1);
        chk("done zcount", cur_zc, zexp);
        if (poke) ld = 1'b0;
        if (!hold) begin
            @(negedge Clock);
            chk("idle done low", cur_done, 0);
            chk("idle ready", cur_ready, 1);
            chk("idle wvalid", cur_wvalid, 0);
            chk("idle zcount held", cur_zc, zexp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn  = 1'b0;
        ld      = 1'b0;
        dat     = 8'h00;
        lsb_sel = 1'b0;
        zmode   = 0;
        #12;
        chk("rst ready", Ready_m, 1);
        chk("rst w", w_m, 0);
        chk("rst wvalid", WValid_m, 0);
        chk("rst done", Done_m, 0);
        chk("rst zcount", ZCount_m, 0);
        chk("rst lsb ready", Ready_l, 1);
        chk("rst lsb zcount", ZCount_l, 0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);

        // MSB-first A5 with z low.
        zmode = 0;
        xfer(8'hA5, 8'hA5, 0, 0, 0, 0, 8'h00);
        // z tied high: every bit counted.
        zmode = 1;
        xfer(8'h3C, 8'h3C, 8, 0, 0, 0, 8'h00);
        // Detector in the loop.
        zmode = 2;
        xfer(8'h00, 8'h00, 0, 0, 0, 0, 8'h00);
        xfer(8'h76, 8'h76, 3, 0, 0, 0, 8'h00);

        // LSB-first instance.
        lsb_sel = 1'b1;
        zmode   = 0;
        xfer(8'h0F, 8'hF0, 0, 0, 0, 0, 8'h00);
        zmode   = 2;
        xfer(8'hA5, 8'hA5, 0, 0, 0, 0, 8'h00);
        lsb_sel = 1'b0;

        // Load pokes at bit 3 and in COLLECT are ignored.
        zmode = 2;
        xfer(8'hC3, 8'hC3, 2, 1, 0, 0, 8'h00);

        // Back-to-back words with Load held through DONE.
        xfer(8'hFF, 8'hFF, 7, 0, 0, 1, 8'h76);
        xfer(8'h76, 8'h76, 3, 0, 1, 0, 8'h00);

        // Reset at bit 4 abandons the word.
        zmode = 1;
        dat   = 8'h5A;
        ld    = 1'b1;
        @(negedge Clock);
        ld = 1'b0;
        repeat (4) @(negedge Clock);
        chk("bit4 wvalid", WValid_m, 1);
        chk("bit4 zcount", ZCount_m, 3);
        #2 Resetn = 1'b0;
        #1;
        chk("mid rst w", w_m, 0);
        chk("mid rst wvalid", WValid_m, 0);
        chk("mid rst zcount", ZCount_m, 0);
        chk("mid rst ready", Ready_m, 1);
        repeat (3) begin
            @(negedge Clock);
            chk("rst no done", Done_m, 0);
        end
        Resetn = 1'b1;
        @(negedge Clock);
        xfer(8'hA5, 8'hA5, 8, 0, 0, 0, 8'h00);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
